// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolution unit:
// branch condition codes, FSM state encoding and flush counter width.
package branch_pkg;

    // funct3 encodings of the conditional branch instructions
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Flush counter width; supports flush lengths of 1..15 cycles
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } br_state_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Redirect channel from the execute stage back to fetch.
// The master (branch_resolve) offers a corrected PC with valid; fetch
// accepts it with ready.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_resolve_cond.sv
// Branch condition evaluator: maps funct3 and the comparator flags to a
// taken decision, and flags the two reserved funct3 encodings.
// Purely combinational so it can be shared with hazard logic.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       equal_i,
    input  logic       less_s_i,
    input  logic       less_u_i,
    output logic       cond_o,
    output logic       illegal_o
);

    // Select the comparison requested by funct3; reserved codes never take
    always_comb begin
        cond_o    = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BR_BEQ:  cond_o = equal_i;
            BR_BNE:  cond_o = ~equal_i;
            BR_BLT:  cond_o = less_s_i;
            BR_BGE:  cond_o = ~less_s_i;
            BR_BLTU: cond_o = less_u_i;
            BR_BGEU: cond_o = ~less_u_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution. Computes the real branch/jump outcome,
// compares it with the fetch prediction and, on a mispredict, sends the
// corrected PC to fetch, stalls EX until accepted, then flushes IF/ID and
// ID/EX for FLUSH_CYCLES cycles.
// Optional: define BRANCH_STATS_EN to add saturating branch and mispredict
// counters (stat_branches, stat_mispredicts).
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_is_branch,
    input  logic                ex_is_jump,
    input  logic [2:0]          ex_funct3,
    input  logic                br_equal,
    input  logic                br_less_s,
    input  logic                br_less_u,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     ex_target,
    input  logic                ex_pred_taken,
    input  logic [XLEN-1:0]     ex_pred_target,
    branch_resolve_if.master    redir,
    output logic                ex_stall,
    output logic                flush_if_id,
    output logic                flush_id_ex,
`ifdef BRANCH_STATS_EN
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts,
`endif
    output logic                illegal_cond
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    br_state_t              state_q;
    logic [XLEN-1:0]        redirect_pc_q;
    logic [XLEN-1:0]        redirect_pc_d;
    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic                   illegal_q;

    logic cond;
    logic cond_illegal;
    logic taken;
    logic mispredict;
    logic illegal_evt;

    branch_cond u_cond (
        .funct3_i  (ex_funct3),
        .equal_i   (br_equal),
        .less_s_i  (br_less_s),
        .less_u_i  (br_less_u),
        .cond_o    (cond),
        .illegal_o (cond_illegal)
    );

    // Resolve the actual outcome and the PC fetch should have used
    always_comb begin
        taken         = ex_is_jump | (ex_is_branch & cond);
        mispredict    = ex_valid & ((taken != ex_pred_taken) |
                                    (taken & (ex_target != ex_pred_target)));
        redirect_pc_d = taken ? ex_target : (ex_pc + XLEN'(4));
        illegal_evt   = ex_valid & ex_is_branch & ~ex_is_jump & cond_illegal;
    end

    // Redirect/flush sequencer; EX is only observed while IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    illegal_q <= illegal_evt;
                    if (mispredict) begin
                        redirect_pc_q <= redirect_pc_d;
                        state_q       <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redir.redirect_ready) begin
                        cnt_q   <= FLUSH_LOAD;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == FLUSH_CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redir.redirect_valid = (state_q == REDIRECT);
    assign redir.redirect_pc    = redirect_pc_q;
    assign ex_stall             = (state_q == REDIRECT);
    assign flush_if_id          = (state_q == FLUSH);
    assign flush_id_ex          = (state_q == FLUSH);
    assign illegal_cond         = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    // Saturating counts of resolved control instructions and mispredicts
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (state_q == IDLE) begin
            if (ex_valid && (ex_is_branch || ex_is_jump) && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict && (stat_mis_q != '1)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule
